yolo_acc_loop_sequencer: RTL and testbench
==========================================

# yolo_acc_loop_sequencer

Sequences the two pipelined sub-functions of the yolo_acc top, the load loop (VITIS_LOOP_25_1) and the compute loop nest (VITIS_LOOP_42_2/45_3/48_4), over a programmable number of tiles. It presents an ap_ctrl_hs handshake upward and drives ap_start, consuming ap_ready and ap_done, on each sub-function. With the performance option enabled, it exposes per-stage cycle counts that the simulation monitors and software read back.

## Interface
- CNT_W, 32, width of performance counters
- TILE_W, 8, width of tile count and tile index
- clock  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-high; all state and outputs to reset values immediately
- ap_start  in  1  top request; sampled only in IDLE
- ap_done  out  1  one-cycle pulse at run end
- ap_ready  out  1  one-cycle pulse, coincident with ap_done
- ap_idle  out  1  high only in IDLE
- tile_count  in  TILE_W  tiles per run; latched when ap_start is accepted
- load_start  out  1  ap_start to the load loop
- load_ready  in  1  load loop accepted its start
- load_done  in  1  load loop finished one tile
- comp_start  out  1  ap_start to the compute loop
- comp_ready  in  1  compute loop accepted its start
- comp_done  in  1  compute loop finished one tile
- tile_idx  out  TILE_W  index of the current tile, 0-based
- load_cycles, comp_cycles, total_cycles  out  CNT_W  performance counters

## Operation
- Moore FSM with states IDLE, LOAD, LOAD_WAIT, COMP, COMP_WAIT, DONE. Every output decodes from registered state or registered counters.
- **IDLE:** when ap_start=1, latch tile_count and clear tile_idx and all counters.
  - If the latched count is 0, go to DONE.
  - Otherwise go to LOAD.
- **LOAD:** load_start=1.
  - load_ready=1 and load_done=1 together: go to COMP.
  - load_ready=1 alone: go to LOAD_WAIT.
  - load_done=1 without load_ready: ignored.
- **LOAD_WAIT:** load_start=0. When load_done=1, go to COMP.
- **COMP and COMP_WAIT:** mirror LOAD and LOAD_WAIT using the comp_* signals. On comp_done:
  - If tile_idx = count-1, go to DONE.
  - Otherwise increment tile_idx and go to LOAD.
- **DONE:** ap_done=1 and ap_ready=1 for exactly one cycle, then go to IDLE. tile_idx holds its last value until the next accepted start.
- **Counters:**
  - load_cycles increments every cycle spent in LOAD or LOAD_WAIT.
  - comp_cycles increments every cycle spent in COMP or COMP_WAIT.
  - total_cycles increments every cycle outside IDLE, including DONE.
  - All three saturate at 2^CNT_W-1, never wrap, and hold after DONE until the next start.
- **Reset values:** state=IDLE, ap_idle=1. ap_done, ap_ready, load_start, comp_start, tile_idx and all counters are 0. Reset mid-run drops any asserted start immediately; the sub-functions are reset by the same reset.

## Timing
- ap_start sampled high in IDLE at cycle 0 produces load_start=1 from cycle 1.
- A start output stays high through the cycle in which ready is sampled high and falls in the next cycle.
- A done sampled at cycle k produces the next stage's start, or DONE, at cycle k+1.
- Minimum run length for one tile, with ready and done returned combinationally in the first start cycle: 4 cycles including DONE. With count=0: 2 cycles, IDLE then DONE.
- ap_start still high in the cycle after DONE starts a new run. There are no back-to-back DONE pulses without an IDLE cycle between them.

## Configuration
- YOLO_SEQ_PERF_CNT_EN defined: the three counters and their saturation logic are built.
- Undefined: the three counter outputs are tied to 0 and the counter registers are omitted. FSM and handshake behaviour is identical either way.

## Structure
- Package yolo_acc_seq_pkg contains:
  - the state enum seq_state_e
  - default widths SEQ_CNT_W=32 and SEQ_TILE_W=8
- Sub-module yolo_acc_sat_counter, used three times: sync clear, enable, saturate at all-ones, async reset to 0.

## Test plan
- **Single tile:** tile_count=1, ready and done returned 2 cycles after each start. Expect one load_start and one comp_start, ap_done at cycle 8, load_cycles=3, comp_cycles=3, total_cycles=7.
- **Multiple tiles:** tile_count=3. Expect starts alternating L,C,L,C,L,C, tile_idx stepping 0,1,2, and exactly one ap_done.
- **Zero tiles:** tile_count=0. Expect no load_start or comp_start, ap_done at cycle 2, total_cycles=1.
- **Same-cycle handshakes and back-to-back runs:** ready and done in the same cycle as start. Expect the LOAD_WAIT/COMP_WAIT states skipped and a 4-cycle run. With ap_start held high, the next run starts at the cycle after DONE.
- **Reset mid-run:** assert reset during COMP_WAIT of tile 1. Expect outputs at reset values within the same cycle and ap_idle=1. A new start then runs cleanly from tile 0.
- **Saturation:** CNT_W=4, hold load_ready low for 20 cycles. Expect load_cycles stuck at 15 and the FSM unaffected. Repeat with the macro undefined: all counters read 0.

Source files
------------

// File: rtl/yolo_acc_seq_pkg.sv
// yolo_acc_seq_pkg: shared types and default widths for the yolo_acc loop
// sequencer.
//   seq_state_e  sequencer FSM state encoding
//   SEQ_CNT_W    default performance counter width
//   SEQ_TILE_W   default tile count / tile index width
package yolo_acc_seq_pkg;

   localparam int SEQ_CNT_W  = 32;
   localparam int SEQ_TILE_W = 8;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD      = 3'd1,
      S_LOAD_WAIT = 3'd2,
      S_COMP      = 3'd3,
      S_COMP_WAIT = 3'd4,
      S_DONE      = 3'd5
   } seq_state_e;

endpackage

// File: rtl/yolo_acc_sat_counter.sv
// yolo_acc_sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   clock  rising-edge clock
//   reset  asynchronous active-high reset, count -> 0
//   clr    synchronous clear, takes priority over en
//   en     count one cycle
//   count  current value
module yolo_acc_sat_counter #(
   parameter int W = 32
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/yolo_acc_loop_sequencer.sv
// yolo_acc_loop_sequencer: runs the load loop and the compute loop nest of
// yolo_acc alternately over tile_count tiles behind an ap_ctrl_hs handshake.
//
// Ports
//   clock, reset            rising-edge clock, async active-high reset
//   ap_start/done/ready/idle upward ap_ctrl_hs handshake
//   tile_count              tiles per run, latched when a start is accepted
//   load_start/ready/done   handshake with the load loop
//   comp_start/ready/done   handshake with the compute loop
//   tile_idx                0-based index of the current tile
//   load_cycles, comp_cycles, total_cycles  per-stage cycle counters
//
// Build option: define YOLO_SEQ_PERF_CNT_EN to build the saturating cycle
// counters; without it the three counter outputs are tied to 0.
//
// state       | meaning
// ------------+-------------------------------------------------
// S_IDLE      | waiting for ap_start, ap_idle high
// S_LOAD      | load_start high, waiting for load_ready
// S_LOAD_WAIT | load accepted, waiting for load_done
// S_COMP      | comp_start high, waiting for comp_ready
// S_COMP_WAIT | compute accepted, waiting for comp_done
// S_DONE      | one-cycle ap_done/ap_ready pulse
module yolo_acc_loop_sequencer
   import yolo_acc_seq_pkg::*;
#(
   parameter int CNT_W  = SEQ_CNT_W,
   parameter int TILE_W = SEQ_TILE_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ap_start,
   output logic              ap_done,
   output logic              ap_ready,
   output logic              ap_idle,
   input  logic [TILE_W-1:0] tile_count,
   output logic              load_start,
   input  logic              load_ready,
   input  logic              load_done,
   output logic              comp_start,
   input  logic              comp_ready,
   input  logic              comp_done,
   output logic [TILE_W-1:0] tile_idx,
   output logic [CNT_W-1:0]  load_cycles,
   output logic [CNT_W-1:0]  comp_cycles,
   output logic [CNT_W-1:0]  total_cycles
);

   seq_state_e        state_q, state_d;
   logic [TILE_W-1:0] count_q;
   logic [TILE_W-1:0] tile_idx_q;
   logic              accept;
   logic              comp_fin;
   logic              last_tile;

   assign accept    = (state_q == S_IDLE) && ap_start;
   // done is only honoured in COMP once ready arrives with it
   assign comp_fin  = ((state_q == S_COMP) && comp_ready && comp_done) ||
                      ((state_q == S_COMP_WAIT) && comp_done);
   assign last_tile = (tile_idx_q == (count_q - TILE_W'(1)));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (ap_start) begin
               state_d = (tile_count == '0) ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: begin
            if (load_ready) begin
               state_d = load_done ? S_COMP : S_LOAD_WAIT;
            end
         end
         S_LOAD_WAIT: begin
            if (load_done) begin
               state_d = S_COMP;
            end
         end
         S_COMP: begin
            if (comp_ready) begin
               if (comp_done) begin
                  state_d = last_tile ? S_DONE : S_LOAD;
               end else begin
                  state_d = S_COMP_WAIT;
               end
            end
         end
         S_COMP_WAIT: begin
            if (comp_done) begin
               state_d = last_tile ? S_DONE : S_LOAD;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ap_idle    = (state_q == S_IDLE);
      ap_done    = (state_q == S_DONE);
      ap_ready   = (state_q == S_DONE);
      load_start = (state_q == S_LOAD);
      comp_start = (state_q == S_COMP);
   end

   // tile_idx keeps its last value after DONE until the next accepted start
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q    <= '0;
         tile_idx_q <= '0;
      end else if (accept) begin
         count_q    <= tile_count;
         tile_idx_q <= '0;
      end else if (comp_fin && !last_tile) begin
         tile_idx_q <= tile_idx_q + TILE_W'(1);
      end
   end

   assign tile_idx = tile_idx_q;

`ifdef YOLO_SEQ_PERF_CNT_EN
   logic load_en;
   logic comp_en;
   logic total_en;

   assign load_en  = (state_q == S_LOAD) || (state_q == S_LOAD_WAIT);
   assign comp_en  = (state_q == S_COMP) || (state_q == S_COMP_WAIT);
   assign total_en = (state_q != S_IDLE);

   yolo_acc_sat_counter #(.W(CNT_W)) u_load_cnt (
      .clock (clock),
      .reset (reset),
      .clr   (accept),
      .en    (load_en),
      .count (load_cycles)
   );

   yolo_acc_sat_counter #(.W(CNT_W)) u_comp_cnt (
      .clock (clock),
      .reset (reset),
      .clr   (accept),
      .en    (comp_en),
      .count (comp_cycles)
   );

   yolo_acc_sat_counter #(.W(CNT_W)) u_total_cnt (
      .clock (clock),
      .reset (reset),
      .clr   (accept),
      .en    (total_en),
      .count (total_cycles)
   );
`else
   assign load_cycles  = '0;
   assign comp_cycles  = '0;
   assign total_cycles = '0;
`endif

endmodule

// File: tb/tb_yolo_acc_loop_sequencer.sv
// tb_yolo_acc_loop_sequencer: scoreboard bench for the yolo_acc loop sequencer.
// The driver picks per-stage ready/done latencies, works out the expected run
// (start pulses, final tile index, stage cycle counts, run length) and queues
// it; a monitor on the falling edge tracks what the DUT does and checks each
// DONE pulse against the queue.
module tb_yolo_acc_loop_sequencer;

   localparam int CNT_W  = 4;
   localparam int TILE_W = 8;
   localparam longint MAXC = (64'd1 << CNT_W) - 1;
`ifdef YOLO_SEQ_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic              clock = 1'b0;
   logic              reset;
   logic              ap_start;
   logic              ap_done, ap_ready, ap_idle;
   logic [TILE_W-1:0] tile_count;
   logic              load_start, load_ready, load_done;
   logic              comp_start, comp_ready, comp_done;
   logic [TILE_W-1:0] tile_idx;
   logic [CNT_W-1:0]  load_cycles, comp_cycles, total_cycles;

   yolo_acc_loop_sequencer #(.CNT_W(CNT_W), .TILE_W(TILE_W)) dut (
      .clock        (clock),
      .reset        (reset),
      .ap_start     (ap_start),
      .ap_done      (ap_done),
      .ap_ready     (ap_ready),
      .ap_idle      (ap_idle),
      .tile_count   (tile_count),
      .load_start   (load_start),
      .load_ready   (load_ready),
      .load_done    (load_done),
      .comp_start   (comp_start),
      .comp_ready   (comp_ready),
      .comp_done    (comp_done),
      .tile_idx     (tile_idx),
      .load_cycles  (load_cycles),
      .comp_cycles  (comp_cycles),
      .total_cycles (total_cycles)
   );

   always #5 clock = ~clock;

   typedef struct {
      int     tiles;
      longint load_sum;
      longint comp_sum;
      longint total;
   } run_exp_t;

   run_exp_t exp_q[$];
   int errors = 0;
   int checks = 0;

   function automatic longint sat(input longint x);
      return (x > MAXC) ? MAXC : x;
   endfunction

   function automatic longint perf(input longint x);
      return PERF ? sat(x) : 64'd0;
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   int     mon_cyc   = 0;
   int     mon_loads = 0;
   int     mon_comps = 0;
   logic   prev_load = 1'b0;
   logic   prev_comp = 1'b0;
   logic   prev_done = 1'b0;
   bit     post_chk  = 1'b0;
   longint post_total;

   always @(negedge clock) begin
      if (reset) begin
         mon_cyc   = 0;
         mon_loads = 0;
         mon_comps = 0;
         prev_load = 1'b0;
         prev_comp = 1'b0;
         prev_done = 1'b0;
         post_chk  = 1'b0;
      end else begin
         if (post_chk) begin
            check("total_hold_after_done", total_cycles, post_total);
            post_chk = 1'b0;
         end
         if (!ap_idle) mon_cyc++;
         if (load_start && !prev_load) begin
            check("tile_idx_at_load", tile_idx, mon_loads);
            mon_loads++;
         end
         if (comp_start && !prev_comp) mon_comps++;
         if (ap_done) begin
            run_exp_t e;
            check("done_not_back_to_back", prev_done, 0);
            check("ap_ready_with_done", ap_ready, 1);
            if (exp_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("load_start_pulses", mon_loads, e.tiles);
               check("comp_start_pulses", mon_comps, e.tiles);
               check("final_tile_idx", tile_idx, (e.tiles == 0) ? 0 : e.tiles - 1);
               check("run_length", mon_cyc, e.total);
               check("load_cycles", load_cycles, perf(e.load_sum));
               check("comp_cycles", comp_cycles, perf(e.comp_sum));
               check("total_at_done", total_cycles, perf(e.total - 1));
               post_total = perf(e.total);
               post_chk   = 1'b1;
            end
            mon_cyc   = 0;
            mon_loads = 0;
            mon_comps = 0;
         end
         prev_load = load_start;
         prev_comp = comp_start;
         prev_done = ap_done;
      end
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One sub-function handshake: ready at offset r, done at offset d (d >= r)
   // counted from the first start cycle; stray done pulses before ready.
   task automatic do_stage(input bit is_load, input int r, input int d);
      int w = 0;
      while (!(is_load ? load_start : comp_start) && w < 50) begin
         tick();
         w++;
      end
      if (w >= 50) begin
         check(is_load ? "load_start_timeout" : "comp_start_timeout", 1, 0);
         return;
      end
      for (int k = 0; k <= d; k++) begin
         logic rd, dn;
         rd = (k == r);
         dn = (k == d) || ((k < r) && ($urandom_range(0, 1) == 1));
         if (is_load) begin
            load_ready = rd;
            load_done  = dn;
         end else begin
            comp_ready = rd;
            comp_done  = dn;
         end
         tick();
      end
      load_ready = 1'b0;
      load_done  = 1'b0;
      comp_ready = 1'b0;
      comp_done  = 1'b0;
   endtask

   task automatic wait_idle();
      int w = 0;
      while (!ap_idle && w < 50) begin
         tick();
         w++;
      end
      if (w >= 50) check("idle_timeout", 1, 0);
   endtask

   // rnd=0 uses latency r/d for every stage; rnd=1 picks them per stage
   task automatic run(input int n, input bit rnd, input int r, input int d);
      int lr[8], ld[8], cr[8], cd[8];
      run_exp_t e;
      e.tiles = n; e.load_sum = 0; e.comp_sum = 0;
      for (int i = 0; i < n; i++) begin
         lr[i] = rnd ? $urandom_range(0, 3) : r;
         ld[i] = rnd ? lr[i] + $urandom_range(0, 3) : d;
         cr[i] = rnd ? $urandom_range(0, 3) : r;
         cd[i] = rnd ? cr[i] + $urandom_range(0, 3) : d;
         e.load_sum += ld[i] + 1;
         e.comp_sum += cd[i] + 1;
      end
      e.total = e.load_sum + e.comp_sum + 1;
      exp_q.push_back(e);
      wait_idle();
      ap_start   = 1'b1;
      tile_count = TILE_W'(n);
      tick();
      ap_start = 1'b0;
      for (int i = 0; i < n; i++) begin
         do_stage(1'b1, lr[i], ld[i]);
         do_stage(1'b0, cr[i], cd[i]);
      end
      wait_idle();
      tick();
   endtask

   initial begin
      run_exp_t e1;
      reset      = 1'b1;
      ap_start   = 1'b0;
      tile_count = '0;
      load_ready = 1'b0;
      load_done  = 1'b0;
      comp_ready = 1'b0;
      comp_done  = 1'b0;
      repeat (3) tick();
      check("rst_ap_idle", ap_idle, 1);
      check("rst_ap_done", ap_done, 0);
      check("rst_load_start", load_start, 0);
      check("rst_tile_idx", tile_idx, 0);
      check("rst_total", total_cycles, 0);
      reset = 1'b0;
      tick();

      // single tile, ready/done two cycles after start
      run(1, 1'b0, 2, 2);
      // three tiles
      run(3, 1'b0, 1, 2);
      // zero tiles
      run(0, 1'b0, 0, 0);
      // same-cycle handshake
      run(1, 1'b0, 0, 0);

      // back-to-back runs with ap_start held through DONE
      e1.tiles = 1; e1.load_sum = 1; e1.comp_sum = 1; e1.total = 3;
      exp_q.push_back(e1);
      exp_q.push_back(e1);
      ap_start   = 1'b1;
      tile_count = 8'd1;
      tick();
      do_stage(1'b1, 0, 0);
      do_stage(1'b0, 0, 0);
      check("b2b_done", ap_done, 1);
      tick();
      check("b2b_idle_between", ap_idle, 1);
      tick();
      check("b2b_second_load", load_start, 1);
      ap_start = 1'b0;
      do_stage(1'b1, 0, 0);
      do_stage(1'b0, 0, 0);
      wait_idle();
      tick();

      // reset during COMP_WAIT of tile 1
      ap_start   = 1'b1;
      tile_count = 8'd3;
      tick();
      ap_start = 1'b0;
      do_stage(1'b1, 0, 0);
      do_stage(1'b0, 0, 0);
      do_stage(1'b1, 1, 1);
      check("pre_rst_comp_start", comp_start, 1);
      comp_ready = 1'b1;
      tick();
      comp_ready = 1'b0;
      tick();
      check("pre_rst_tile_idx", tile_idx, 1);
      check("pre_rst_comp_wait", comp_start | ap_idle, 0);
      reset = 1'b1;
      #1;
      check("midrst_ap_idle", ap_idle, 1);
      check("midrst_comp_start", comp_start, 0);
      check("midrst_tile_idx", tile_idx, 0);
      check("midrst_comp_cycles", comp_cycles, 0);
      tick();
      reset = 1'b0;
      exp_q.delete();
      tick();
      run(3, 1'b1, 0, 0);

      // saturation: load_ready held low for 20 cycles
      run(1, 1'b0, 20, 20);

      // random runs
      for (int i = 0; i < 12; i++) begin
         run($urandom_range(0, 4), 1'b1, 0, 0);
      end

      repeat (5) tick();
      check("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
